// File: rtl/river_log_ctrl.sv
// One river-row log that steps along a wrapping 20-column board.
// It also flags log pixels, detects frog-on-log and raises carry/drown pulses.
module river_log_ctrl #(
    parameter int c_MAX_X      = 20,
    parameter int c_LOG_LEN    = 3,
    parameter int c_SLOW_COUNT = 4000000,
    parameter int c_INIT_X     = 0,
    parameter int c_INIT_Y     = 4,
    parameter int c_DIR        = 0
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Game_Active,
    input  logic [4:0] i_Col_Count_Div,
    input  logic [4:0] i_Row_Count_Div,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    output logic [5:0] o_Log_X,
    output logic [5:0] o_Log_Y,
    output logic       o_Log_Draw,
    output logic       o_On_Log,
    output logic       o_Carry_Pulse,
    output logic       o_Carry_Dir,
    output logic       o_Drowned
);
    localparam int PW = $clog2(c_SLOW_COUNT);
    localparam logic [PW-1:0] PRE_LAST = PW'(c_SLOW_COUNT - 1);
    localparam logic [5:0] LAST_X = 6'(c_MAX_X - 1);
    localparam logic [5:0] EXIT_X = (c_DIR == 0) ? 6'(c_MAX_X - 1) : 6'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP} state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic            water;
    logic            frog_row;
    logic            frog_hit;
    logic            water_now;
    logic            at_exit;
    logic            step_drown;
    logic            step_carry;
    logic            drown_now;
    logic [5:0]      head_next;

    // Offset from the head, folded into 0..c_MAX_X-1 with one compare-and-add.
    function automatic logic in_log(input logic [5:0] x, input logic [5:0] head);
        logic [6:0] diff;
        if (x >= head)
            diff = {1'b0, x} - {1'b0, head};
        else
            diff = {1'b0, x} + 7'(c_MAX_X) - {1'b0, head};
        return (x < 6'(c_MAX_X)) && (diff < 7'(c_LOG_LEN));
    endfunction

    always_comb begin
        frog_row   = (i_Frogger_Y == 6'(c_INIT_Y));
        frog_hit   = frog_row && in_log(i_Frogger_X, o_Log_X);
        water_now  = frog_row && !frog_hit;
        at_exit    = (i_Frogger_X == EXIT_X);
        // Carry/drown decisions use the on-log flag registered before the step.
        step_drown = (state == ST_STEP) && o_On_Log && at_exit;
        step_carry = (state == ST_STEP) && o_On_Log && !at_exit;
        drown_now  = step_drown || (water_now && !water);
        if (c_DIR == 0)
            head_next = (o_Log_X == LAST_X) ? 6'd0 : o_Log_X + 6'd1;
        else
            head_next = (o_Log_X == 6'd0) ? LAST_X : o_Log_X - 6'd1;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state         <= ST_IDLE;
            prescaler     <= '0;
            water         <= 1'b0;
            o_Log_X       <= 6'(c_INIT_X);
            o_Log_Y       <= 6'(c_INIT_Y);
            o_Log_Draw    <= 1'b0;
            o_On_Log      <= 1'b0;
            o_Carry_Pulse <= 1'b0;
            o_Carry_Dir   <= 1'(c_DIR);
            o_Drowned     <= 1'b0;
        end else begin
            o_Log_Y       <= 6'(c_INIT_Y);
            o_Carry_Dir   <= 1'(c_DIR);
            o_Log_Draw    <= (i_Row_Count_Div == 5'(c_INIT_Y)) &&
                             in_log({1'b0, i_Col_Count_Div}, o_Log_X);
            o_On_Log      <= frog_hit;
            water         <= water_now;
            o_Drowned     <= drown_now;
            o_Carry_Pulse <= step_carry && !drown_now;

            case (state)
                ST_IDLE: begin
                    prescaler <= '0;
                    if (i_Game_Active)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!i_Game_Active) begin
                        state     <= ST_IDLE;
                        prescaler <= '0;
                    end else if (prescaler == PRE_LAST) begin
                        state     <= ST_STEP;
                        prescaler <= '0;
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
                ST_STEP: begin
                    o_Log_X   <= head_next;
                    prescaler <= '0;
                    state     <= i_Game_Active ? ST_RUN : ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    prescaler <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_river_log_ctrl.sv
// Bench for river_log_ctrl: a rightward and a leftward instance share stimulus
// and are checked every cycle against an arithmetic reference model.
module tb_river_log_ctrl;
    localparam int MAX_X = 20;
    localparam int LEN   = 3;
    localparam int SLOW  = 4;
    localparam int ROW   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       active = 1'b0;
    logic [4:0] col = '0;
    logic [4:0] row = '0;
    logic [5:0] fx = '0;
    logic [5:0] fy = '0;

    logic [1:0][5:0] log_x;
    logic [1:0][5:0] log_y;
    logic [1:0]      draw;
    logic [1:0]      on_log;
    logic [1:0]      carry;
    logic [1:0]      cdir;
    logic [1:0]      drowned;

    int checks = 0;
    int fails  = 0;

    int init_x[2] = '{0, 1};
    int dirs[2]   = '{0, 1};

    // reference model state
    bit m_running;
    int m_phase;
    int m_log[2];
    bit m_cond[2];
    bit e_draw[2];
    bit e_on[2];
    bit e_carry[2];
    bit e_drown[2];

    typedef struct {
        logic [4:0] col;
        logic [4:0] row;
        bit         exp;
    } vec_t;
    vec_t vecs[24];

    always #5 clk = ~clk;

    river_log_ctrl #(.c_MAX_X(MAX_X), .c_LOG_LEN(LEN), .c_SLOW_COUNT(SLOW),
                     .c_INIT_X(0), .c_INIT_Y(ROW), .c_DIR(0)) dut_r (
        .i_Clk(clk), .i_Reset(rst), .i_Game_Active(active),
        .i_Col_Count_Div(col), .i_Row_Count_Div(row),
        .i_Frogger_X(fx), .i_Frogger_Y(fy),
        .o_Log_X(log_x[0]), .o_Log_Y(log_y[0]), .o_Log_Draw(draw[0]),
        .o_On_Log(on_log[0]), .o_Carry_Pulse(carry[0]), .o_Carry_Dir(cdir[0]),
        .o_Drowned(drowned[0])
    );

    river_log_ctrl #(.c_MAX_X(MAX_X), .c_LOG_LEN(LEN), .c_SLOW_COUNT(SLOW),
                     .c_INIT_X(1), .c_INIT_Y(ROW), .c_DIR(1)) dut_l (
        .i_Clk(clk), .i_Reset(rst), .i_Game_Active(active),
        .i_Col_Count_Div(col), .i_Row_Count_Div(row),
        .i_Frogger_X(fx), .i_Frogger_Y(fy),
        .o_Log_X(log_x[1]), .o_Log_Y(log_y[1]), .o_Log_Draw(draw[1]),
        .o_On_Log(on_log[1]), .o_Carry_Pulse(carry[1]), .o_Carry_Dir(cdir[1]),
        .o_Drowned(drowned[1])
    );

    function automatic bit member(int x, int head);
        return (x < MAX_X) && ((((x - head) % MAX_X) + MAX_X) % MAX_X < LEN);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_running = 0;
        m_phase   = 0;
        for (int i = 0; i < 2; i++) begin
            m_log[i]   = init_x[i];
            m_cond[i]  = 0;
            e_draw[i]  = 0;
            e_on[i]    = 0;
            e_carry[i] = 0;
            e_drown[i] = 0;
        end
    endtask

    // One clock edge of the model, using inputs as they stood before the edge.
    task automatic model_edge();
        bit step_now;
        step_now = m_running && (m_phase == SLOW);
        for (int i = 0; i < 2; i++) begin
            int exit_col;
            bit hit, cond, water, sd, sc;
            exit_col   = (dirs[i] != 0) ? 0 : MAX_X - 1;
            hit        = (int'(fy) == ROW) && member(int'(fx), m_log[i]);
            cond       = (int'(fy) == ROW) && !hit;
            water      = cond && !m_cond[i];
            sd         = step_now && e_on[i] && (int'(fx) == exit_col);
            sc         = step_now && e_on[i] && (int'(fx) != exit_col);
            e_draw[i]  = (int'(row) == ROW) && member(int'(col), m_log[i]);
            e_on[i]    = hit;
            e_drown[i] = sd || water;
            e_carry[i] = sc && !e_drown[i];
            m_cond[i]  = cond;
            if (step_now)
                m_log[i] = (m_log[i] + ((dirs[i] != 0) ? -1 : 1) + MAX_X) % MAX_X;
        end
        if (!m_running) begin
            if (active) begin
                m_running = 1;
                m_phase   = 0;
            end
        end else if (!active) begin
            m_running = 0;
            m_phase   = 0;
        end else begin
            m_phase = (m_phase + 1) % (SLOW + 1);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("log_x[%0d]", i), int'(log_x[i]), m_log[i]);
            check($sformatf("log_y[%0d]", i), int'(log_y[i]), ROW);
            check($sformatf("draw[%0d]", i), int'(draw[i]), int'(e_draw[i]));
            check($sformatf("on_log[%0d]", i), int'(on_log[i]), int'(e_on[i]));
            check($sformatf("carry[%0d]", i), int'(carry[i]), int'(e_carry[i]));
            check($sformatf("carry_dir[%0d]", i), int'(cdir[i]), dirs[i]);
            check($sformatf("drowned[%0d]", i), int'(drowned[i]), int'(e_drown[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic check_reset(string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_log_x[%0d]", tag, i), int'(log_x[i]), init_x[i]);
            check($sformatf("%s_log_y[%0d]", tag, i), int'(log_y[i]), ROW);
            check($sformatf("%s_draw[%0d]", tag, i), int'(draw[i]), 0);
            check($sformatf("%s_on_log[%0d]", tag, i), int'(on_log[i]), 0);
            check($sformatf("%s_carry[%0d]", tag, i), int'(carry[i]), 0);
            check($sformatf("%s_drowned[%0d]", tag, i), int'(drowned[i]), 0);
        end
        check($sformatf("%s_prescaler", tag), int'(dut_r.prescaler), 0);
    endtask

    // Called just after a compare (posedge+1); reset lands between edges.
    task automatic apply_reset(string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_log(int target, int budget, string name);
        int n = 0;
        while (int'(log_x[0]) != target && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(log_x[0]), target);
    endtask

    task automatic wait_step(int budget);
        int n = 0;
        int start;
        start = int'(log_x[0]);
        while (int'(log_x[0]) == start && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        for (int c = 0; c < 20; c++) begin
            vecs[c].col = 5'(c);
            vecs[c].row = 5'(ROW);
            vecs[c].exp = (c == 18) || (c == 19) || (c == 0);
        end
        vecs[20] = '{col: 5'd18, row: 5'd5, exp: 1'b0};
        vecs[21] = '{col: 5'd0,  row: 5'd5, exp: 1'b0};
        vecs[22] = '{col: 5'd19, row: 5'd3, exp: 1'b0};
        vecs[23] = '{col: 5'd17, row: 5'd4, exp: 1'b0};

        // power-on reset
        rst = 1'b1;
        fx  = 6'd5;
        fy  = 6'd5;
        #3;
        model_reset();
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // frog on log, then the first step carries it
        fx = 6'd1;
        fy = 6'd4;
        tick();
        check("t3_on_log", int'(on_log[0]), 1);
        active = 1'b1;
        repeat (5) tick();
        check("t3_no_early_carry", int'(carry[0]), 0);
        tick();
        check("t3_carry", int'(carry[0]), 1);
        check("t3_carry_dir", int'(cdir[0]), 0);
        check("t3_step_x", int'(log_x[0]), 1);
        check("t3_left_step_x", int'(log_x[1]), 0);
        fx = 6'd2;
        tick();
        check("t3_carry_one_cycle", int'(carry[0]), 0);

        // step cadence of SLOW+1 clocks and leftward wrap 0 -> 19
        repeat (3) tick();
        check("t1_hold_x", int'(log_x[0]), 1);
        tick();
        check("t1_next_step_x", int'(log_x[0]), 2);
        check("t1_left_wrap", int'(log_x[1]), 19);
        fx = 6'd5;
        fy = 6'd5;

        // frog at the exit column drowns at the step
        wait_log(17, 200, "t4_reach_17");
        fx = 6'd19;
        fy = 6'd4;
        tick();
        check("t4_on_log", int'(on_log[0]), 1);
        wait_step(20);
        check("t4_drowned", int'(drowned[0]), 1);
        check("t4_no_carry", int'(carry[0]), 0);
        check("t4_step_x", int'(log_x[0]), 18);
        tick();
        check("t4_drown_one_cycle", int'(drowned[0]), 0);
        fx = 6'd5;
        fy = 6'd5;

        // rightward wrap 19 -> 0
        wait_log(19, 50, "t1_reach_19");
        wait_step(20);
        check("t1_right_wrap", int'(log_x[0]), 0);

        // pixel draw scan with the log parked at 18
        wait_log(18, 200, "t2_reach_18");
        active = 1'b0;
        tick();
        check("t2_prescaler_idle", int'(dut_r.prescaler), 0);
        for (int v = 0; v < 24; v++) begin
            col = vecs[v].col;
            row = vecs[v].row;
            tick();
            check($sformatf("t2_draw_c%0d_r%0d", vecs[v].col, vecs[v].row),
                  int'(draw[0]), int'(vecs[v].exp));
            $display("draw col=%0d row=%0d -> %0d (want %0d)",
                     vecs[v].col, vecs[v].row, draw[0], vecs[v].exp);
        end

        // frog lands in water: a single drown pulse
        apply_reset("t5_reset");
        tick();
        fx = 6'd10;
        fy = 6'd4;
        tick();
        check("t5_water_drown", int'(drowned[0]), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t5_no_repeat_%0d", k), int'(drowned[0]), 0);
        end

        // dropping active freezes the log; reset mid-run aborts
        fx = 6'd5;
        fy = 6'd5;
        active = 1'b1;
        repeat (3) tick();
        active = 1'b0;
        tick();
        check("t6_prescaler_cleared", int'(dut_r.prescaler), 0);
        repeat (10) tick();
        check("t6_frozen", int'(log_x[0]), 0);
        active = 1'b1;
        repeat (6) tick();
        check("t6_running_x", int'(log_x[0]), 1);
        repeat (2) tick();
        apply_reset("t6_reset");
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            active = ($urandom_range(0, 19) != 0);
            col    = 5'($urandom_range(0, 31));
            row    = 5'($urandom_range(2, 6));
            if ($urandom_range(0, 5) == 0) begin
                fx = 6'($urandom_range(0, 23));
                fy = 6'($urandom_range(3, 5));
            end
            if ($urandom_range(0, 499) == 0)
                apply_reset("rand_reset");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
